// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/gnt + rvalid handshake
// and holds one instruction for the Controller until the datapath retires it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] next_pc;
  logic        retire;
  logic        target_misaligned;

  // Both adds wrap modulo 2^32; the carry out is intentionally dropped.
  assign pc_plus4          = pc_q + 32'd4;
  assign next_pc           = PCSrc ? (pc_q + ImmExt) : pc_plus4;
  assign target_misaligned = |next_pc[1:0];
  assign retire            = (state == S_VALID) && advance;

  // State register: reset is asynchronous so imem_req drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   if (imem_gnt) state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_next = S_VALID;
      S_VALID: if (advance) state_next = target_misaligned ? S_ERROR : S_REQ;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    imem_req     = 1'b0;
    inst_valid   = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      S_REQ:   imem_req     = 1'b1;
      S_VALID: inst_valid   = 1'b1;
      S_ERROR: misalign_err = 1'b1;
      default: ;
    endcase
  end

  // PC and instruction holding register. PCSrc/ImmExt only matter on a retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
    end else if (retire) begin
      if (!target_misaligned) begin
        pc_q   <= next_pc;
        inst_q <= NOP_INST;
      end
    end else if ((state == S_WAIT) && imem_rvalid) begin
      inst_q <= imem_rdata;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  // inst_q still holds the last word in ERROR, so gate it explicitly.
  assign inst      = inst_valid ? inst_q : NOP_INST;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory responder with randomized gnt/rvalid
// delays and an architectural PC model (pc+4 or pc+imm, modulo 2^32).
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = '0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        misalign_err;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_pc;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ImmExt(ImmExt), .advance(advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst(inst), .pc(pc),
    .pc_plus4(pc_plus4), .inst_valid(inst_valid), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural next-PC rule.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic s,
                                             input logic [31:0] imm);
    return s ? cur + imm : cur + 32'd4;
  endfunction

  // Memory responder, called at a negedge. Waits (bounded) for a request, holds gnt
  // low for gd cycles, returns data rd cycles after the grant. With noise set it
  // toggles advance/PCSrc/ImmExt and pulses rvalid in REQ, all of which must be ignored.
  task automatic serve(input int gd, input int rd, input logic [31:0] data, input bit noise,
                       output logic [31:0] addr, output bit ok, output bit stable);
    int n = 0;
    ok = 1'b1;
    stable = 1'b1;
    addr = 'x;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      ok = 1'b0;
      return;
    end
    addr = imem_addr;
    repeat (gd) begin
      advance     = noise ? 1'($urandom) : 1'b0;
      PCSrc       = 1'($urandom);
      ImmExt      = $urandom;
      imem_rvalid = noise ? 1'($urandom) : 1'b0;
      imem_rdata  = $urandom;
      @(negedge clk);
      if (!imem_req || imem_addr !== addr || inst_valid || inst !== NOP || pc !== addr)
        stable = 1'b0;
    end
    imem_rvalid = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (rd) begin
      advance = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (imem_req || inst_valid || inst !== NOP || pc !== addr) stable = 1'b0;
    end
    advance     = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
  endtask

  // Retire the current instruction; control inputs are scrambled afterwards.
  task automatic retire(input logic s, input logic [31:0] imm);
    advance = 1'b1;
    PCSrc   = s;
    ImmExt  = imm;
    @(negedge clk);
    advance = 1'b0;
    PCSrc   = 1'($urandom);
    ImmExt  = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pc !== 32'h0 || inst !== NOP || inst_valid !== 1'b0 || imem_req !== 1'b0 ||
        misalign_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h inst=%h valid=%b req=%b err=%b want 0/%h/0/0/0",
               pc, inst, inst_valid, imem_req, misalign_err, NOP);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    @(negedge clk);
    exp_pc = 32'h0;
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    bit ok, st;
    serve(0, 0, 32'h0010_0093, 1'b0, a, ok, st);
    tests_run++;
    if (!ok || a !== 32'h0 || inst_valid !== 1'b1 || inst !== 32'h0010_0093 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL seq_fetch: ok=%b addr=%h valid=%b inst=%h pc=%h want 1/0/1/00100093/0",
               ok, a, inst_valid, inst, pc);
    end
    retire(1'b0, 32'h0);
    exp_pc = model_next(exp_pc, 1'b0, 32'h0);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL seq_next_addr: req=%b addr=%h want 1/%h", imem_req, imem_addr, exp_pc);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a;
    bit ok, st;
    // Walk sequentially up to pc=0x10.
    for (int i = 0; i < 3; i++) begin
      serve(0, 0, $urandom, 1'b0, a, ok, st);
      retire(1'b0, 32'h0);
      exp_pc = model_next(exp_pc, 1'b0, 32'h0);
    end
    serve(0, 0, 32'h0000_0063, 1'b0, a, ok, st);
    tests_run++;
    if (!ok || pc !== 32'h10 || inst_valid !== 1'b1 || exp_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL branch_setup: ok=%b pc=%h valid=%b want pc=00000010 valid=1", ok, pc, inst_valid);
    end
    retire(1'b1, 32'hFFFF_FFF8);
    exp_pc = model_next(exp_pc, 1'b1, 32'hFFFF_FFF8);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc !== 32'h8 || pc_plus4 !== 32'hC) begin
      tests_failed++;
      $display("FAIL branch_taken: req=%b addr=%h pc=%h pc_plus4=%h want 1/8/8/C",
               imem_req, imem_addr, pc, pc_plus4);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] d;
    bit ok, st;
    d = $urandom;
    serve(3, 4, d, 1'b1, a, ok, st);
    tests_run++;
    if (!ok || !st || a !== exp_pc) begin
      tests_failed++;
      $display("FAIL backpressure_hold: ok=%b stable=%b addr=%h want 1/1/%h", ok, st, a, exp_pc);
    end
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== d || pc !== exp_pc) begin
      tests_failed++;
      $display("FAIL backpressure_data: valid=%b inst=%h pc=%h want 1/%h/%h",
               inst_valid, inst, pc, d, exp_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] imm;
    logic        s;
    bit ok, st;
    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom);
      imm = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
      retire(s, imm);
      exp_pc = model_next(exp_pc, s, imm);
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        tests_failed++;
        $display("FAIL rand_next[%0d]: req=%b addr=%h pc_plus4=%h want 1/%h/%h",
                 i, imem_req, imem_addr, pc_plus4, exp_pc, exp_pc + 32'd4);
      end
      d = $urandom;
      serve($urandom_range(0, 3), $urandom_range(0, 3), d, 1'($urandom), a, ok, st);
      tests_run++;
      if (!ok || !st || inst_valid !== 1'b1 || inst !== d || pc !== exp_pc) begin
        tests_failed++;
        $display("FAIL rand_fetch[%0d]: ok=%b stable=%b valid=%b inst=%h pc=%h want inst=%h pc=%h",
                 i, ok, st, inst_valid, inst, pc, d, exp_pc);
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] a;
    logic [31:0] imm;
    bit ok, st;
    imm = 32'hFFFF_FFFC - exp_pc;
    retire(1'b1, imm);
    exp_pc = model_next(exp_pc, 1'b1, imm);
    serve(0, 0, $urandom, 1'b0, a, ok, st);
    tests_run++;
    if (!ok || pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_setup: ok=%b pc=%h pc_plus4=%h want FFFFFFFC/00000000", ok, pc, pc_plus4);
    end
    retire(1'b0, 32'h0);
    exp_pc = model_next(exp_pc, 1'b0, 32'h0);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || exp_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    // Grant it, then reset while the read is outstanding.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || inst_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset: req=%b pc=%h valid=%b want 0/00000000/0", imem_req, pc, inst_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL late_rvalid: valid=%b inst=%h req=%b addr=%h want 0/%h/1/00000000",
               inst_valid, inst, imem_req, imem_addr, NOP);
    end
    exp_pc = 32'h0;
    serve(1, 1, 32'h0000_0513, 1'b0, a, ok, st);
    tests_run++;
    if (!ok || inst !== 32'h0000_0513 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL refetch_after_reset: ok=%b inst=%h pc=%h want 00000513/00000000", ok, inst, pc);
    end
  endtask

  task automatic test_misaligned();
    retire(1'b1, 32'h6);
    tests_run++;
    if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h0 ||
        inst !== NOP) begin
      tests_failed++;
      $display("FAIL misalign_enter: err=%b valid=%b req=%b pc=%h inst=%h want 1/0/0/0/%h",
               misalign_err, inst_valid, imem_req, pc, inst, NOP);
    end
    for (int i = 0; i < 6; i++) begin
      advance     = 1'($urandom);
      imem_gnt    = 1'($urandom);
      imem_rvalid = 1'($urandom);
      @(negedge clk);
    end
    advance = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    tests_run++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL misalign_sticky: err=%b req=%b valid=%b pc=%h want 1/0/0/0",
               misalign_err, imem_req, inst_valid, pc);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (misalign_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_clear: err=%b want 0", misalign_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_random();
    test_wrap_reset();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
